ctrl_entrada: RTL and testbench

Sequencing controller for the operand-entry and result-display path. It collects keypad digits into a 4-digit BCD entry buffer and latches two operands. It then hands them to the arithmetic unit with a start pulse and waits for completion. It drives the `ent` select of the downstream display multiplexer: `numero` is shown while entering, `resultado` is shown after completion.

---
 rtl/ctrl_entrada.sv | 159 +++++++++++++++
 tb/tb_ctrl_entrada.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_entrada.sv
// Operand-entry sequencer: collects BCD keypad digits, latches two operands,
// launches the arithmetic unit and selects entry or result for the display mux.
module ctrl_entrada #(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  key_valid_i,
  input  logic [3:0]            key_code_i,
  input  logic                  done_i,
  output logic [N_DIG-1:0][3:0] numero_o,
  output logic [N_DIG-1:0][3:0] op_a_o,
  output logic [N_DIG-1:0][3:0] op_b_o,
  output logic                  start_o,
  output logic                  ent_o,
  output logic                  err_o,
  output logic [2:0]            state_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] CntMax = 3'(N_DIG);

  localparam logic [3:0] KeyEnter    = 4'hA;
  localparam logic [3:0] KeyClrEntry = 4'hB;
  localparam logic [3:0] KeyClrAll   = 4'hC;

  localparam logic [2:0] StEntryA = 3'd0;
  localparam logic [2:0] StEntryB = 3'd1;
  localparam logic [2:0] StCalc   = 3'd2;
  localparam logic [2:0] StShow   = 3'd3;
  localparam logic [2:0] StErr    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [N_DIG-1:0][3:0] numero_q, numero_d;
  logic [N_DIG-1:0][3:0] op_a_q, op_a_d;
  logic [N_DIG-1:0][3:0] op_b_q, op_b_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  start_q, start_d;
  logic                  ent_q, ent_d;
  logic                  err_q, err_d;

  logic is_digit, is_enter, is_clr_entry, is_clr_all;

  assign is_digit     = key_valid_i && (key_code_i <= 4'd9);
  assign is_enter     = key_valid_i && (key_code_i == KeyEnter);
  assign is_clr_entry = key_valid_i && (key_code_i == KeyClrEntry);
  assign is_clr_all   = key_valid_i && (key_code_i == KeyClrAll);

  // Next-state decode; CLR_ALL dominates every state, done dominates timeout.
  always_comb begin
    state_d  = state_q;
    numero_d = numero_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    start_d  = 1'b0;

    if (is_clr_all) begin
      state_d  = StEntryA;
      numero_d = '0;
      op_a_d   = '0;
      op_b_d   = '0;
      cnt_d    = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        StEntryA, StEntryB: begin
          if (is_digit) begin
            // A full buffer silently drops further digits.
            if (cnt_q < CntMax) begin
              numero_d = {numero_q[N_DIG-2:0], key_code_i};
              cnt_d    = cnt_q + 3'd1;
            end
          end else if (is_enter) begin
            if (state_q == StEntryA) begin
              op_a_d  = numero_q;
              state_d = StEntryB;
            end else begin
              op_b_d  = numero_q;
              state_d = StCalc;
              timer_d = '0;
              start_d = 1'b1;
            end
            numero_d = '0;
            cnt_d    = '0;
          end else if (is_clr_entry) begin
            numero_d = '0;
            cnt_d    = '0;
          end
        end
        StCalc: begin
          if (done_i) begin
            state_d = StShow;
          end else if (timer_q == TimerMax) begin
            state_d = StErr;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StShow: begin
          // A new digit starts the next operand A; operands stay until ENTER.
          if (is_digit) begin
            numero_d    = '0;
            numero_d[0] = key_code_i;
            cnt_d       = 3'd1;
            state_d     = StEntryA;
          end
        end
        StErr: begin
          state_d = StErr;
        end
        default: begin
          state_d = StEntryA;
        end
      endcase
    end

    ent_d = (state_d == StShow);
    err_d = (state_d == StErr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StEntryA;
      numero_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      ent_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      numero_q <= numero_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      ent_q    <= ent_d;
      err_q    <= err_d;
    end
  end

  assign numero_o = numero_q;
  assign op_a_o   = op_a_q;
  assign op_b_o   = op_b_q;
  assign start_o  = start_q;
  assign ent_o    = ent_q;
  assign err_o    = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ctrl_entrada.sv
// Scoreboard bench for ctrl_entrada: a decimal-value model predicts every
// cycle's outputs, and a monitor compares them one cycle at a time.
module tb_ctrl_entrada;

  localparam int unsigned T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            key_valid = 1'b0;
  logic [3:0]      key_code = 4'h0;
  logic            done = 1'b0;
  logic [3:0][3:0] numero, op_a, op_b;
  logic            start, ent, err;
  logic [2:0]      state;

  ctrl_entrada #(
    .N_DIG       (4),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .done_i      (done),
    .numero_o    (numero),
    .op_a_o      (op_a),
    .op_b_o      (op_b),
    .start_o     (start),
    .ent_o       (ent),
    .err_o       (err),
    .state_o     (state)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] numero;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        start;
    logic        ent;
    logic        err;
    logic [2:0]  state;
  } exp_t;

  exp_t exp_q[$];

  // Model: operands as plain decimal numbers, mode as the debug state number.
  int m_mode = 0;
  int m_val  = 0;
  int m_len  = 0;
  int m_a    = 0;
  int m_b    = 0;
  int m_wait = 0;
  bit m_start = 0;

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic r, input logic kv, input logic [3:0] k,
                            input logic d);
    m_start = 0;
    if (r || (kv && k == 4'hC)) begin
      m_mode = 0; m_val = 0; m_len = 0; m_a = 0; m_b = 0; m_wait = 0;
    end else begin
      case (m_mode)
        0, 1: if (kv) begin
          if (k <= 4'd9) begin
            if (m_len < 4) begin
              m_val = m_val * 10 + int'(k);
              m_len++;
            end
          end else if (k == 4'hA) begin
            if (m_mode == 0) begin
              m_a = m_val;
              m_mode = 1;
            end else begin
              m_b = m_val;
              m_mode = 2;
              m_wait = 0;
              m_start = 1;
            end
            m_val = 0;
            m_len = 0;
          end else if (k == 4'hB) begin
            m_val = 0;
            m_len = 0;
          end
        end
        2: begin
          if (d) m_mode = 3;
          else begin
            m_wait++;
            if (m_wait == int'(T)) m_mode = 4;
          end
        end
        3: if (kv && k <= 4'd9) begin
          m_val = int'(k);
          m_len = 1;
          m_mode = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after its edge.
  task automatic cyc(input logic r, input logic kv, input logic [3:0] k, input logic d);
    exp_t e;
    @(negedge clk);
    rst = r;
    key_valid = kv;
    key_code = k;
    done = d;
    model_step(r, kv, k, d);
    e.numero = bcd(m_val);
    e.op_a   = bcd(m_a);
    e.op_b   = bcd(m_b);
    e.start  = m_start;
    e.ent    = (m_mode == 3);
    e.err    = (m_mode == 4);
    e.state  = 3'(m_mode);
    exp_q.push_back(e);
  endtask

  task automatic key(input logic [3:0] k);
    cyc(1'b0, 1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Monitor: the DUT presents registered outputs every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("numero", numero, e.numero);
        chk("op_a", op_a, e.op_a);
        chk("op_b", op_b, e.op_b);
        chk("start", {15'd0, start}, {15'd0, e.start});
        chk("ent", {15'd0, ent}, {15'd0, e.ent});
        chk("err", {15'd0, err}, {15'd0, e.err});
        chk("state", {13'd0, state}, {13'd0, e.state});
      end
    end
  end

  initial begin
    int x;
    logic [3:0] k;
    // Reset and idle.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    idle(2);
    // Full operation with a dropped fifth digit, then done at +3.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'hA);
    key(4'd9); key(4'hA);
    idle(2);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    idle(2);
    // Enter/CLR_ENTRY ignored in SHOW, digit returns to entry.
    key(4'hA); key(4'hB); key(4'd7);
    idle(1);
    // Timeout, ignored keys in ERR, then CLR_ALL.
    key(4'hC); key(4'd1); key(4'hA); key(4'd2); key(4'hA);
    idle(T + 2);
    key(4'd3); key(4'hA); cyc(1'b0, 1'b0, 4'h0, 1'b1); key(4'hC);
    idle(1);
    // Abort: CLR_ALL together with done, then a late done.
    key(4'd1); key(4'hA); key(4'd2); key(4'hA);
    idle(1);
    cyc(1'b0, 1'b1, 4'hC, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    idle(2);
    // Entry clear, then reset mid-entry overriding a key and done.
    key(4'd4); key(4'd5); key(4'hB); key(4'd6); key(4'hA);
    key(4'd3); key(4'd4);
    cyc(1'b1, 1'b1, 4'd5, 1'b1);
    idle(1);
    // Randomized traffic including back-to-back keys.
    for (int i = 0; i < 3000; i++) begin
      x = $urandom_range(0, 19);
      if (x < 10) k = 4'(x);
      else if (x < 13) k = 4'hA;
      else if (x == 13) k = 4'hB;
      else if (x == 14) k = 4'hC;
      else k = 4'(13 + (x - 15) % 3);
      cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), k,
          ($urandom_range(0, 5) == 0));
    end
    idle(1);
    repeat (3) @(negedge clk);
    chk("drain", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
